// File: rtl/cpu_debug_slave_sysclk_mc.sv
// Debug slave: moves JTAG update-DR/update-IR events from the TCK domain into
// the system clock domain, presents one command at a time on a per-channel
// valid/ready handshake, and reports dropped or timed-out commands.
`timescale 1ns/1ps
module cpu_debug_slave_sysclk_mc #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int CH_W        = 2,
  parameter int SYNC_STAGES = 3,
  parameter int TO_W        = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   vs_udr,
  input  logic                   vs_uir,
  input  logic [SR_W-1:0]        sr,
  input  logic [IR_W-1:0]        ir_in,
  input  logic [CH_W-1:0]        ch_sel,
  output logic                   cmd_valid,
  output logic [CH_W-1:0]        cmd_ch,
  output logic [IR_W-1:0]        cmd_ir,
  output logic [SR_W-1:0]        cmd_data,
  input  logic [(2**CH_W)-1:0]   cmd_ready,
  output logic                   ir_strobe,
  output logic [IR_W-1:0]        ir_cur,
  output logic                   ack_tgl,
  output logic                   ovr_flag,
  output logic                   to_flag,
  input  logic                   flag_clr
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
  logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   udr_edge_q, udr_edge_d;
  logic                   uir_edge_q, uir_edge_d;
  logic                   udr_arm_q, udr_arm_d;
  logic                   uir_arm_q, uir_arm_d;
  logic                   udr_evt_q, udr_evt_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [CH_W-1:0]        cmd_ch_q, cmd_ch_d;
  logic [IR_W-1:0]        cmd_ir_q, cmd_ir_d;
  logic [SR_W-1:0]        cmd_data_q, cmd_data_d;
  logic                   ir_strobe_q, ir_strobe_d;
  logic [IR_W-1:0]        ir_cur_q, ir_cur_d;
  logic                   ack_tgl_q, ack_tgl_d;
  logic                   ovr_flag_q, ovr_flag_d;
  logic                   to_flag_q, to_flag_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic                   accept_s;
  logic                   ovr_set_s;
  logic                   to_set_s;

  // Synchroniser chains, edge detection and event arming.
  // fill tracks how far real samples have propagated since reset; an edge is
  // only honoured once the synchronised level has been seen low on real data,
  // so a level already high at reset release never fires.
  always_comb begin
    udr_sync_d  = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
    uir_sync_d  = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
    fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
    udr_edge_d  = udr_sync_q[SYNC_STAGES-1];
    uir_edge_d  = uir_sync_q[SYNC_STAGES-1];
    udr_arm_d   = udr_arm_q | (fill_q[SYNC_STAGES-1] & ~udr_sync_q[SYNC_STAGES-1]);
    uir_arm_d   = uir_arm_q | (fill_q[SYNC_STAGES-1] & ~uir_sync_q[SYNC_STAGES-1]);
    udr_evt_d   = udr_sync_q[SYNC_STAGES-1] & ~udr_edge_q & udr_arm_q;
    ir_strobe_d = uir_sync_q[SYNC_STAGES-1] & ~uir_edge_q & uir_arm_q;
    if (ir_strobe_d) begin
      ir_cur_d = ir_in;
    end else begin
      ir_cur_d = ir_cur_q;
    end
  end

  // Command FSM: capture in IDLE, hold and wait for the addressed ready in PEND.
  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_ch_d    = cmd_ch_q;
    cmd_ir_d    = cmd_ir_q;
    cmd_data_d  = cmd_data_q;
    to_cnt_d    = to_cnt_q;
    ack_tgl_d   = ack_tgl_q;
    ovr_set_s   = 1'b0;
    to_set_s    = 1'b0;
    accept_s    = cmd_ready[cmd_ch_q];
    case (state_q)
      IDLE: begin
        cmd_valid_d = 1'b0;
        if (udr_evt_q) begin
          cmd_data_d  = sr;
          cmd_ir_d    = ir_in;
          cmd_ch_d    = ch_sel;
          cmd_valid_d = 1'b1;
          to_cnt_d    = {TO_W{1'b0}};
          state_d     = PEND;
        end else begin
          state_d     = IDLE;
        end
      end
      PEND: begin
        // A new update-DR while a command is outstanding is always dropped.
        ovr_set_s = udr_evt_q;
        if (accept_s) begin
          cmd_valid_d = 1'b0;
          ack_tgl_d   = ~ack_tgl_q;
          state_d     = IDLE;
        end else if (to_cnt_q == {TO_W{1'b1}}) begin
          cmd_valid_d = 1'b0;
          to_set_s    = 1'b1;
          state_d     = IDLE;
        end else begin
          to_cnt_d    = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        cmd_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
    // Sticky flags: a set in the same cycle as a clear wins.
    if (ovr_set_s) begin
      ovr_flag_d = 1'b1;
    end else if (flag_clr) begin
      ovr_flag_d = 1'b0;
    end else begin
      ovr_flag_d = ovr_flag_q;
    end
    if (to_set_s) begin
      to_flag_d = 1'b1;
    end else if (flag_clr) begin
      to_flag_d = 1'b0;
    end else begin
      to_flag_d = to_flag_q;
    end
  end

  // State register for every flop in the block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      udr_sync_q  <= {SYNC_STAGES{1'b0}};
      uir_sync_q  <= {SYNC_STAGES{1'b0}};
      fill_q      <= {SYNC_STAGES{1'b0}};
      udr_edge_q  <= 1'b0;
      uir_edge_q  <= 1'b0;
      udr_arm_q   <= 1'b0;
      uir_arm_q   <= 1'b0;
      udr_evt_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_ch_q    <= {CH_W{1'b0}};
      cmd_ir_q    <= {IR_W{1'b0}};
      cmd_data_q  <= {SR_W{1'b0}};
      ir_strobe_q <= 1'b0;
      ir_cur_q    <= {IR_W{1'b0}};
      ack_tgl_q   <= 1'b0;
      ovr_flag_q  <= 1'b0;
      to_flag_q   <= 1'b0;
      to_cnt_q    <= {TO_W{1'b0}};
    end else begin
      state_q     <= state_d;
      udr_sync_q  <= udr_sync_d;
      uir_sync_q  <= uir_sync_d;
      fill_q      <= fill_d;
      udr_edge_q  <= udr_edge_d;
      uir_edge_q  <= uir_edge_d;
      udr_arm_q   <= udr_arm_d;
      uir_arm_q   <= uir_arm_d;
      udr_evt_q   <= udr_evt_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_ch_q    <= cmd_ch_d;
      cmd_ir_q    <= cmd_ir_d;
      cmd_data_q  <= cmd_data_d;
      ir_strobe_q <= ir_strobe_d;
      ir_cur_q    <= ir_cur_d;
      ack_tgl_q   <= ack_tgl_d;
      ovr_flag_q  <= ovr_flag_d;
      to_flag_q   <= to_flag_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_ch    = cmd_ch_q;
  assign cmd_ir    = cmd_ir_q;
  assign cmd_data  = cmd_data_q;
  assign ir_strobe = ir_strobe_q;
  assign ir_cur    = ir_cur_q;
  assign ack_tgl   = ack_tgl_q;
  assign ovr_flag  = ovr_flag_q;
  assign to_flag   = to_flag_q;

endmodule

// File: tb/tb_cpu_debug_slave_sysclk_mc.sv
// Self-checking bench for cpu_debug_slave_sysclk_mc (TO_W reduced to 4).
`timescale 1ns/1ps
module tb_cpu_debug_slave_sysclk_mc;
  localparam int SR_W = 38;
  localparam int IR_W = 2;
  localparam int CH_W = 2;
  localparam int SYNC = 3;
  localparam int TO_W = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            vs_udr = 1'b0;
  logic            vs_uir = 1'b0;
  logic [SR_W-1:0] sr = '0;
  logic [IR_W-1:0] ir_in = '0;
  logic [CH_W-1:0] ch_sel = '0;
  logic            cmd_valid;
  logic [CH_W-1:0] cmd_ch;
  logic [IR_W-1:0] cmd_ir;
  logic [SR_W-1:0] cmd_data;
  logic [3:0]      cmd_ready = 4'b0000;
  logic            ir_strobe;
  logic [IR_W-1:0] ir_cur;
  logic            ack_tgl;
  logic            ovr_flag;
  logic            to_flag;
  logic            flag_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic exp_ack = 1'b0;
  logic exp_ovr = 1'b0;
  logic exp_to  = 1'b0;
  logic [IR_W-1:0] exp_ir_cur = '0;

  cpu_debug_slave_sysclk_mc #(
    .SR_W(SR_W), .IR_W(IR_W), .CH_W(CH_W), .SYNC_STAGES(SYNC), .TO_W(TO_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .sr(sr), .ir_in(ir_in), .ch_sel(ch_sel),
    .cmd_valid(cmd_valid), .cmd_ch(cmd_ch), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .ir_strobe(ir_strobe), .ir_cur(ir_cur),
    .ack_tgl(ack_tgl), .ovr_flag(ovr_flag), .to_flag(to_flag), .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_ack"}, 64'(ack_tgl), 64'(exp_ack));
    chk({tag, "_ovr"}, 64'(ovr_flag), 64'(exp_ovr));
    chk({tag, "_to"},  64'(to_flag),  64'(exp_to));
  endtask

  // Raise vs_udr and expect cmd_valid exactly SYNC+1 cycles after the first
  // synchroniser sample, with the driven fields captured.
  task automatic issue(input logic [SR_W-1:0] d, input logic [IR_W-1:0] i,
                       input logic [CH_W-1:0] c, input string tag);
    sr = d; ir_in = i; ch_sel = c; vs_udr = 1'b1;
    tick();
    for (int k = 1; k <= SYNC; k++) begin
      tick();
      chk({tag, "_lat"}, 64'(cmd_valid), 64'd0);
    end
    tick();
    chk({tag, "_valid"}, 64'(cmd_valid), 64'd1);
    chk({tag, "_data"},  64'(cmd_data),  64'(d));
    chk({tag, "_ir"},    64'(cmd_ir),    64'(i));
    chk({tag, "_ch"},    64'(cmd_ch),    64'(c));
  endtask

  task automatic release_udr();
    vs_udr = 1'b0;
    repeat (SYNC + 2) tick();
  endtask

  task automatic clear_flags();
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    exp_ovr = 1'b0;
    exp_to  = 1'b0;
  endtask

  function automatic logic [SR_W-1:0] rnd_data();
    return {6'($urandom), 32'($urandom)};
  endfunction

  initial begin
    logic [SR_W-1:0] d1;
    logic [3:0]      rr;
    logic [CH_W-1:0] rc;
    logic [IR_W-1:0] ri;
    int              wait_n;
    int              pulses;

    // Reset state
    repeat (3) tick();
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_ch",    64'(cmd_ch),    64'd0);
    chk("rst_ir",    64'(cmd_ir),    64'd0);
    chk("rst_data",  64'(cmd_data),  64'd0);
    chk("rst_strobe",64'(ir_strobe), 64'd0);
    chk("rst_ircur", 64'(ir_cur),    64'd0);
    chk_flags("rst");
    reset_n = 1'b1;
    repeat (5) tick();

    // Basic command with the target ready already high
    cmd_ready = 4'b0100;
    issue(38'h2A_DEADBEEF, 2'b10, 2'd2, "basic");
    tick();
    exp_ack = ~exp_ack;
    chk("basic_drop", 64'(cmd_valid), 64'd0);
    chk_flags("basic");
    cmd_ready = 4'b0000;
    release_udr();

    // Ready on other channels is ignored
    issue(rnd_data(), 2'($urandom), 2'd1, "wrongch");
    cmd_ready = 4'b1101;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("wrongch_hold", 64'(cmd_valid), 64'd1);
    end
    cmd_ready = 4'b0010;
    tick();
    exp_ack = ~exp_ack;
    chk("wrongch_drop", 64'(cmd_valid), 64'd0);
    chk_flags("wrongch");
    cmd_ready = 4'b0000;
    release_udr();

    // Overrun: second update-DR while pending is dropped
    d1 = rnd_data();
    issue(d1, 2'b01, 2'd0, "ovr");
    vs_udr = 1'b0;
    repeat (4) tick();
    sr = 38'h1;
    vs_udr = 1'b1;
    repeat (5) tick();
    exp_ovr = 1'b1;
    chk("ovr_keep_data", 64'(cmd_data), 64'(d1));
    chk("ovr_keep_valid", 64'(cmd_valid), 64'd1);
    chk_flags("ovr_set");
    cmd_ready = 4'b0001;
    tick();
    exp_ack = ~exp_ack;
    chk("ovr_drop", 64'(cmd_valid), 64'd0);
    chk_flags("ovr_acc");
    cmd_ready = 4'b0000;
    clear_flags();
    chk_flags("ovr_clr");
    release_udr();

    // Acceptance and new update-DR in the same cycle
    issue(rnd_data(), 2'b11, 2'd3, "same");
    vs_udr = 1'b0;
    repeat (4) tick();
    sr = rnd_data();
    vs_udr = 1'b1;
    repeat (SYNC + 1) tick();
    cmd_ready = 4'b1000;
    tick();
    exp_ack = ~exp_ack;
    exp_ovr = 1'b1;
    chk("same_drop", 64'(cmd_valid), 64'd0);
    chk_flags("same");
    cmd_ready = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("same_nocap", 64'(cmd_valid), 64'd0);
    end
    clear_flags();
    release_udr();

    // Timeout: valid held for 2**TO_W cycles in PEND, then dropped
    issue(rnd_data(), 2'b00, 2'd3, "to");
    cmd_ready = 4'b0111;
    for (int k = 1; k < (1 << TO_W); k++) begin
      tick();
      chk("to_hold", 64'(cmd_valid), 64'd1);
    end
    tick();
    exp_to = 1'b1;
    chk("to_drop", 64'(cmd_valid), 64'd0);
    chk_flags("to");
    cmd_ready = 4'b0000;
    release_udr();
    cmd_ready = 4'b0010;
    issue(rnd_data(), 2'b01, 2'd1, "to_next");
    tick();
    exp_ack = ~exp_ack;
    chk("to_next_drop", 64'(cmd_valid), 64'd0);
    chk_flags("to_next");
    cmd_ready = 4'b0000;
    clear_flags();
    chk_flags("to_clr");
    release_udr();

    // Randomised commands with random ready delay and distractor readies
    for (int n = 0; n < 20; n++) begin
      rc = 2'($urandom);
      ri = 2'($urandom);
      d1 = rnd_data();
      wait_n = $urandom_range(0, 12);
      issue(d1, ri, rc, "rnd");
      for (int k = 0; k < wait_n; k++) begin
        rr = 4'($urandom);
        rr[rc] = 1'b0;
        cmd_ready = rr;
        tick();
        chk("rnd_hold", 64'(cmd_valid), 64'd1);
        chk("rnd_data", 64'(cmd_data), 64'(d1));
      end
      rr = 4'($urandom);
      rr[rc] = 1'b1;
      cmd_ready = rr;
      tick();
      exp_ack = ~exp_ack;
      chk("rnd_drop", 64'(cmd_valid), 64'd0);
      chk_flags("rnd");
      cmd_ready = 4'b0000;
      release_udr();
    end

    // IR path: one strobe per update-IR, ir_cur latched
    for (int n = 0; n < 2; n++) begin
      ri = (n == 0) ? 2'b11 : 2'($urandom);
      ir_in = ri;
      vs_uir = 1'b1;
      pulses = 0;
      repeat (8) begin
        tick();
        if (ir_strobe) pulses++;
      end
      exp_ir_cur = ri;
      chk("ir_pulses", 64'(pulses), 64'd1);
      chk("ir_cur", 64'(ir_cur), 64'(exp_ir_cur));
      vs_uir = 1'b0;
      repeat (SYNC + 2) tick();
    end

    // Reset while pending, with vs_udr held high through release
    issue(rnd_data(), 2'b10, 2'd1, "rstp");
    tick();
    reset_n = 1'b0;
    #2;
    exp_ack = 1'b0; exp_ovr = 1'b0; exp_to = 1'b0; exp_ir_cur = '0;
    chk("rstp_valid", 64'(cmd_valid), 64'd0);
    chk("rstp_data",  64'(cmd_data),  64'd0);
    chk("rstp_ch",    64'(cmd_ch),    64'd0);
    chk("rstp_ir",    64'(cmd_ir),    64'd0);
    chk("rstp_ircur", 64'(ir_cur),    64'(exp_ir_cur));
    chk_flags("rstp");
    repeat (2) tick();
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("rstp_noevt", 64'(cmd_valid), 64'd0);
    end
    chk_flags("rstp_after");
    release_udr();
    cmd_ready = 4'b0001;
    issue(rnd_data(), 2'b01, 2'd0, "rstp_next");
    tick();
    exp_ack = ~exp_ack;
    chk("rstp_next_drop", 64'(cmd_valid), 64'd0);
    chk_flags("rstp_next");
    cmd_ready = 4'b0000;
    release_udr();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
